parking_gate_scheduler: RTL and testbench

Sequences car events from NUM_GATES physical gates into the single-event Parking_LOT occupancy datapath. It arbitrates between the gates' requests and issues one entered or exited event per transaction. It waits for the datapath's ready indication, then grants or denies the requesting gate. It sits between the gate sensors/barrier controllers and the lot counter, and is the only driver of the lot's car_entered/is_uni_car_entered/car_exited/is_uni_car_exited inputs.

---
 rtl/parking_gate_scheduler_if.sv | 37 +++
 rtl/parking_gate_scheduler.sv | 219 +++++++++++++++++++++
 tb/tb_parking_gate_scheduler.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/parking_gate_scheduler_if.sv
// Gate/lot bundle for the parking gate scheduler.
// The master side is the environment: the gate sensors driving requests and the
// lot datapath driving its status flags. The slave side is the scheduler, which
// answers the gates and drives the lot's single-event inputs.
interface parking_gate_scheduler_if #(
    parameter int NUM_GATES = 4
);
    // Gate side: one request/direction/class level per gate, one pulse pair back
    logic [NUM_GATES-1:0] gate_req;
    logic [NUM_GATES-1:0] gate_dir;
    logic [NUM_GATES-1:0] gate_uni;
    logic [NUM_GATES-1:0] gate_grant;
    logic [NUM_GATES-1:0] gate_deny;

    // Lot datapath side
    logic                 lot_car_entered;
    logic                 lot_is_uni_entered;
    logic                 lot_car_exited;
    logic                 lot_is_uni_exited;
    logic                 lot_ready;
    logic                 lot_uni_space;
    logic                 lot_space;

    modport master (
        output gate_req, gate_dir, gate_uni,
        output lot_ready, lot_uni_space, lot_space,
        input  gate_grant, gate_deny,
        input  lot_car_entered, lot_is_uni_entered, lot_car_exited, lot_is_uni_exited
    );

    modport slave (
        input  gate_req, gate_dir, gate_uni,
        input  lot_ready, lot_uni_space, lot_space,
        output gate_grant, gate_deny,
        output lot_car_entered, lot_is_uni_entered, lot_car_exited, lot_is_uni_exited
    );
endinterface

// File: rtl/parking_gate_scheduler.sv
// Parking gate scheduler.
// Serialises car events from NUM_GATES gates into the single-event lot
// occupancy datapath. Exit requests beat entry requests; inside a class the
// gates are served round-robin. Each transaction either issues one lot event
// and waits for the lot's ready edge, or is denied (no space / timeout).
module parking_gate_scheduler #(
    parameter int NUM_GATES = 4,
    parameter int TIMEOUT   = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    parking_gate_scheduler_if.slave  bus,
    output logic                     busy,
    output logic                     timeout_err,
    output logic [15:0]              served_count
);

    localparam int               IDX_W      = $clog2(NUM_GATES);
    localparam logic [7:0]       WAIT_LIMIT = 8'(TIMEOUT);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_GATES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_CHECK,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t               state;

    // Round-robin pointer and the gates that must drop their request before
    // they may be arbitrated again.
    logic [IDX_W-1:0]     rr_ptr;
    logic [NUM_GATES-1:0] hold_mask;

    // Winner captured in ARB; only meaningful from CHECK to RESP.
    logic [IDX_W-1:0]     win_idx;
    logic                 win_dir;
    logic                 win_uni;
    logic [NUM_GATES-1:0] win_onehot;

    // Ready edge detection and wait-cycle counter.
    logic                 ready_prev;
    logic [7:0]           wait_cnt;

    // Registered outputs.
    logic [NUM_GATES-1:0] grant_q;
    logic [NUM_GATES-1:0] deny_q;
    logic                 ent_q;
    logic                 ent_uni_q;
    logic                 ext_q;
    logic                 ext_uni_q;

    // Arbitration terms.
    logic [NUM_GATES-1:0] elig;
    logic [NUM_GATES-1:0] exit_req;
    logic [NUM_GATES-1:0] entry_req;
    logic [NUM_GATES-1:0] class_req;
    logic [IDX_W:0]       pick;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_vld;
    logic                 space_ok;

    // First requesting gate at or after ptr, ascending with wrap.
    // Returns {found, index}. Iterating from the farthest offset down lets the
    // nearest hit overwrite the others, so no early exit is needed.
    function automatic logic [IDX_W:0] rr_pick(
        input logic [NUM_GATES-1:0] req,
        input logic [IDX_W-1:0]     ptr
    );
        logic [IDX_W:0] res;
        int             k;
        res = '0;
        for (int i = NUM_GATES - 1; i >= 0; i--) begin
            k = (int'(ptr) + i) % NUM_GATES;
            if (req[IDX_W'(k)]) begin
                res = {1'b1, IDX_W'(k)};
            end
        end
        return res;
    endfunction

    // Eligible requests, class selection (exits first) and round-robin pick.
    always_comb begin
        elig      = bus.gate_req & ~hold_mask;
        exit_req  = elig & bus.gate_dir;
        entry_req = elig & ~bus.gate_dir;
        class_req = (|exit_req) ? exit_req : entry_req;
        pick      = rr_pick(class_req, rr_ptr);
        pick_vld  = pick[IDX_W];
        pick_idx  = pick[IDX_W-1:0];
        space_ok  = win_uni ? bus.lot_uni_space : bus.lot_space;
    end

    assign win_onehot = {{(NUM_GATES-1){1'b0}}, 1'b1} << win_idx;

    // Capture the winner's index and attributes in ARB; pure data, no reset.
    always_ff @(posedge clk) begin
        if (state == S_ARB && pick_vld) begin
            win_idx <= pick_idx;
            win_dir <= bus.gate_dir[pick_idx];
            win_uni <= bus.gate_uni[pick_idx];
        end
    end

    // Transaction FSM with all control state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            rr_ptr       <= '0;
            hold_mask    <= '0;
            ready_prev   <= 1'b0;
            wait_cnt     <= '0;
            grant_q      <= '0;
            deny_q       <= '0;
            ent_q        <= 1'b0;
            ent_uni_q    <= 1'b0;
            ext_q        <= 1'b0;
            ext_uni_q    <= 1'b0;
            busy         <= 1'b0;
            timeout_err  <= 1'b0;
            served_count <= '0;
        end else begin
            // Pulses last exactly one cycle; a gate leaves the hold set once
            // its request has been seen low.
            grant_q   <= '0;
            deny_q    <= '0;
            hold_mask <= hold_mask & bus.gate_req;

            case (state)
                S_IDLE: begin
                    if (|elig) begin
                        state <= S_ARB;
                        busy  <= 1'b1;
                    end
                end

                S_ARB: begin
                    // Requests may have vanished since IDLE; fall back if so.
                    if (pick_vld) begin
                        state <= S_CHECK;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end

                S_CHECK: begin
                    if (win_dir) begin
                        ext_q     <= 1'b1;
                        ext_uni_q <= win_uni;
                        state     <= S_ISSUE;
                    end else if (space_ok) begin
                        ent_q     <= 1'b1;
                        ent_uni_q <= win_uni;
                        state     <= S_ISSUE;
                    end else begin
                        deny_q <= win_onehot;
                        state  <= S_RESP;
                    end
                end

                S_ISSUE: begin
                    // A ready level already high here must not count as completion.
                    ready_prev <= bus.lot_ready;
                    wait_cnt   <= 8'd1;
                    state      <= S_WAIT;
                end

                S_WAIT: begin
                    ready_prev <= bus.lot_ready;
                    if (bus.lot_ready && !ready_prev) begin
                        ent_q     <= 1'b0;
                        ent_uni_q <= 1'b0;
                        ext_q     <= 1'b0;
                        ext_uni_q <= 1'b0;
                        grant_q   <= win_onehot;
                        state     <= S_RESP;
                    end else if (wait_cnt == WAIT_LIMIT) begin
                        ent_q       <= 1'b0;
                        ent_uni_q   <= 1'b0;
                        ext_q       <= 1'b0;
                        ext_uni_q   <= 1'b0;
                        timeout_err <= 1'b1;
                        deny_q      <= win_onehot;
                        state       <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                S_RESP: begin
                    if (|grant_q) begin
                        served_count <= served_count + 16'd1;
                    end
                    rr_ptr             <= (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
                    hold_mask[win_idx] <= 1'b1;
                    state              <= S_IDLE;
                    busy               <= 1'b0;
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gate_grant         = grant_q;
    assign bus.gate_deny          = deny_q;
    assign bus.lot_car_entered    = ent_q;
    assign bus.lot_is_uni_entered = ent_uni_q;
    assign bus.lot_car_exited     = ext_q;
    assign bus.lot_is_uni_exited  = ext_uni_q;

endmodule

// File: tb/tb_parking_gate_scheduler.sv
// Testbench for parking_gate_scheduler: directed scenarios followed by random
// request batches, checked against a transaction-level reference model.
module tb_parking_gate_scheduler;

    localparam int NG = 4;
    localparam int TO = 15;
    localparam int IW = $clog2(NG);

    logic        clk;
    logic        rst_n;
    logic        busy;
    logic        timeout_err;
    logic [15:0] served_count;

    parking_gate_scheduler_if #(.NUM_GATES(NG)) bus ();

    parking_gate_scheduler #(.NUM_GATES(NG), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus.slave),
        .busy         (busy),
        .timeout_err  (timeout_err),
        .served_count (served_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int gate;
        bit dir;
        bit uni;
        bit issued;
        bit grant;
    } txn_t;

    txn_t          expq[$];
    int            vectors     = 0;
    int            miscompares = 0;
    int            cyc         = 0;
    int            delay_cfg   = 1;
    bit            stuck_cfg   = 0;
    bit            early_cfg   = 0;
    logic [NG-1:0] keep_req    = '0;
    bit            lot_active  = 0;
    int            issue_cyc   = 0;
    logic [3:0]    lot_pat     = '0;
    int            s_cyc       = 0;
    int            srv_model   = 0;
    bit            terr_model  = 0;
    int            ptr_model   = 0;
    bit            cnt_pending = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [3:0] lot_bits();
        return {bus.lot_car_entered, bus.lot_is_uni_entered,
                bus.lot_car_exited, bus.lot_is_uni_exited};
    endfunction

    task automatic check_zero(input string pfx);
        check({pfx, "_grant"}, 32'(bus.gate_grant), 32'd0);
        check({pfx, "_deny"},  32'(bus.gate_deny),  32'd0);
        check({pfx, "_lot"},   32'(lot_bits()),     32'd0);
        check({pfx, "_busy"},  32'(busy),           32'd0);
        check({pfx, "_terr"},  32'(timeout_err),    32'd0);
        check({pfx, "_count"}, 32'(served_count),   32'd0);
    endtask

    // Reference model: service order and outcome of a batch of simultaneous requests.
    task automatic build_expected(input logic [NG-1:0] req, input logic [NG-1:0] dir,
                                  input logic [NG-1:0] uni, input bit sp, input bit usp,
                                  input bit stuck, input int dly);
        logic [NG-1:0] pend;
        logic [NG-1:0] cls;
        txn_t          t;
        int            g;
        bit            found;
        pend = req;
        while (pend != '0) begin
            cls   = ((pend & dir) != '0) ? (pend & dir) : (pend & ~dir);
            found = 0;
            g     = 0;
            for (int k = 0; k < NG; k++) begin
                if (!found && cls[IW'((ptr_model + k) % NG)]) begin
                    found = 1;
                    g     = (ptr_model + k) % NG;
                end
            end
            t.gate   = g;
            t.dir    = dir[IW'(g)];
            t.uni    = uni[IW'(g)];
            t.issued = t.dir || (t.uni ? usp : sp);
            t.grant  = t.issued && !stuck && dly >= 1 && dly <= TO;
            expq.push_back(t);
            pend[IW'(g)] = 1'b0;
            ptr_model    = (g + 1) % NG;
        end
    endtask

    // One clock of environment: gate and lot behaviour plus all checks.
    task automatic step();
        logic [3:0]    cur;
        logic [3:0]    ep;
        logic [NG-1:0] eg;
        logic [NG-1:0] ed;
        txn_t          h;
        int            w;
        tick();
        cur = lot_bits();
        check("exclusive_lot", 32'(cur[3] & cur[1]), 32'd0);
        if (cnt_pending) begin
            check("served_count", 32'(served_count), 32'(srv_model[15:0]));
            cnt_pending = 0;
        end
        if (lot_active) begin
            if (cur == 4'b0) begin
                lot_active = 0;
                if (!stuck_cfg) bus.lot_ready = 1'b0;
            end else begin
                check("lot_hold", 32'(cur), 32'(lot_pat));
            end
        end else if (cur != 4'b0) begin
            lot_active = 1;
            issue_cyc  = cyc;
            lot_pat    = cur;
            if (expq.size() == 0) begin
                check("issue_unexpected", 32'(cur), 32'd0);
            end else begin
                h  = expq[0];
                ep = !h.issued ? 4'b0 : (h.dir ? {3'b001, h.uni} : {1'b1, h.uni, 2'b00});
                check("issue_pattern", 32'(cur), 32'(ep));
                check("issue_time", 32'(cyc), 32'(s_cyc + 3));
                if (early_cfg) bus.gate_req[IW'(h.gate)] = 1'b0;
            end
        end
        if (lot_active && !stuck_cfg && (cyc - issue_cyc == delay_cfg)) bus.lot_ready = 1'b1;
        if ((bus.gate_grant | bus.gate_deny) != '0) begin
            if (expq.size() == 0) begin
                check("pulse_unexpected", 32'({bus.gate_grant, bus.gate_deny}), 32'd0);
            end else begin
                h  = expq.pop_front();
                eg = h.grant ? (NG'(1) << h.gate) : '0;
                ed = h.grant ? '0 : (NG'(1) << h.gate);
                check("grant_vec", 32'(bus.gate_grant), 32'(eg));
                check("deny_vec",  32'(bus.gate_deny),  32'(ed));
                w = h.issued ? 4 + (h.grant ? delay_cfg : TO) : 3;
                check("pulse_time", 32'(cyc), 32'(s_cyc + w));
                check("lot_off_in_resp", 32'(cur), 32'd0);
                check("busy_in_resp", 32'(busy), 32'd1);
                if (h.grant) srv_model++;
                else if (h.issued) terr_model = 1;
                check("timeout_err", 32'(timeout_err), 32'(terr_model));
                cnt_pending = 1;
                s_cyc       = cyc + 1;
                if (!keep_req[IW'(h.gate)]) bus.gate_req[IW'(h.gate)] = 1'b0;
            end
        end
    endtask

    task automatic run_batch(input logic [NG-1:0] req, input logic [NG-1:0] dir,
                             input logic [NG-1:0] uni, input bit sp, input bit usp,
                             input int dly, input bit stuck, input bit early);
        delay_cfg         = dly;
        stuck_cfg         = stuck;
        early_cfg         = early;
        bus.lot_space     = sp;
        bus.lot_uni_space = usp;
        if (stuck) bus.lot_ready = 1'b1;
        build_expected(req, dir, uni, sp, usp, stuck, dly);
        bus.gate_dir = dir;
        bus.gate_uni = uni;
        bus.gate_req = req;
        s_cyc        = cyc;
        for (int k = 0; k < 600 && expq.size() != 0; k++) step();
        if (expq.size() != 0) begin
            check("drain_bound", 32'(expq.size()), 32'd0);
            expq.delete();
        end
        for (int k = 0; k < 3; k++) step();
        check("busy_after_batch", 32'(busy), 32'd0);
        if (stuck) bus.lot_ready = 1'b0;
        stuck_cfg = 0;
        early_cfg = 0;
    endtask

    initial begin
        logic [NG-1:0] rreq;
        rst_n             = 1'b0;
        bus.gate_req      = '0;
        bus.gate_dir      = '0;
        bus.gate_uni      = '0;
        bus.lot_ready     = 1'b0;
        bus.lot_space     = 1'b0;
        bus.lot_uni_space = 1'b0;
        repeat (3) tick();
        check_zero("reset");
        rst_n = 1'b1;
        tick();
        tick();
        check_zero("post_reset");

        // Reset in the middle of WAIT aborts the entry with no pulse.
        bus.lot_space = 1'b1;
        bus.gate_req  = 4'b0010;
        for (int k = 0; k < 20 && bus.lot_car_entered !== 1'b1; k++) tick();
        check("t1_entered", 32'(bus.lot_car_entered), 32'd1);
        tick();
        tick();
        check("t1_hold_in_wait", 32'(bus.lot_car_entered), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_zero("t1_async");
        bus.gate_req = '0;
        tick();
        check_zero("t1_held");
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_zero("t1_release");
        end
        srv_model  = 0;
        terr_model = 0;
        ptr_model  = 0;

        // Round-robin among entries 0,1,3, then gate 0 again.
        run_batch(4'b1011, 4'b0000, 4'b0000, 1'b1, 1'b1, 2, 1'b0, 1'b0);
        run_batch(4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b1, 1, 1'b0, 1'b0);
        // Single uni entry, ready three cycles after issue.
        run_batch(4'b0010, 4'b0000, 4'b0010, 1'b0, 1'b1, 3, 1'b0, 1'b0);
        // Exit at gate 2 beats entry at gate 0.
        run_batch(4'b0101, 4'b0100, 4'b0000, 1'b1, 1'b1, 1, 1'b0, 1'b0);
        // Lot full for general cars.
        run_batch(4'b1000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1, 1'b0, 1'b0);
        // Exit with ready never rising: timeout.
        run_batch(4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b1, TO + 5, 1'b0, 1'b0);
        // Later grants leave timeout_err set.
        run_batch(4'b0011, 4'b0000, 4'b0001, 1'b1, 1'b1, 4, 1'b0, 1'b0);
        // Ready exactly at the limit still completes.
        run_batch(4'b0100, 4'b0100, 4'b0000, 1'b1, 1'b1, TO, 1'b0, 1'b0);

        // A gate holding its request after the grant is not served again.
        keep_req = 4'b0100;
        run_batch(4'b0100, 4'b0000, 4'b0000, 1'b1, 1'b1, 2, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) step();
        check("hold_no_rearb_busy", 32'(busy), 32'd0);
        keep_req     = '0;
        bus.gate_req = '0;
        step();
        step();
        run_batch(4'b0100, 4'b0000, 4'b0000, 1'b1, 1'b1, 2, 1'b0, 1'b0);

        // Ready already high at issue is not a completion.
        run_batch(4'b0010, 4'b0010, 4'b0000, 1'b1, 1'b1, 1, 1'b1, 1'b0);
        // Request dropped during the transaction still gets its pulse.
        run_batch(4'b1000, 4'b1000, 4'b1000, 1'b1, 1'b1, 5, 1'b0, 1'b1);

        // Random batches.
        for (int b = 0; b < 30; b++) begin
            rreq = NG'($urandom_range(1, (1 << NG) - 1));
            run_batch(rreq, NG'($urandom), NG'($urandom),
                      ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                      $urandom_range(1, TO + 3), 1'b0, ($urandom_range(0, 4) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
